// File: rtl/enc_stream_feeder.sv
// Feeds a 36-bit block cipher core: assembles key/plaintext from a 9-bit stream and returns ciphertext as 4 words.
// One block in flight; output words hold under out_ready=0, input stalls via in_ready.
module enc_stream_feeder #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [8:0]   in_data,
  input  logic         in_valid,
  input  logic         in_is_key,
  output logic         in_ready,
  output logic [143:0] keyin,
  output logic [35:0]  S_I,
  output logic         encrypt_en,
  input  logic         encr_done,
  input  logic [35:0]  S_j,
  output logic [8:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_loaded,
  output logic         busy,
  output logic         err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    kcnt;
  logic [1:0]    bcnt;
  logic [1:0]    ocnt;
  logic [TW-1:0] tcnt;
  logic [35:0]   cap;
  logic          in_xfer;
  logic          out_xfer;
  logic          tmo;

  // Key words are held off mid-block so the key cannot change under a half-built block.
  assign in_ready  = (state == LOAD) && (in_is_key ? (bcnt == 2'd0) : key_loaded);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state == DRAIN);
  assign out_data  = cap[35:27];
  assign out_xfer  = out_valid && out_ready;
  assign busy      = (state != LOAD);
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_xfer && !in_is_key && bcnt == 2'd3) state_nxt = START;
      START:   if (!encr_done) state_nxt = WAIT;
      WAIT: begin
        if (encr_done) state_nxt = DRAIN;
        else if (tmo)  state_nxt = LOAD;
      end
      DRAIN:   if (out_xfer && ocnt == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyin      <= '0;
      S_I        <= '0;
      encrypt_en <= 1'b0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
      kcnt       <= '0;
      bcnt       <= '0;
      ocnt       <= '0;
      tcnt       <= '0;
      cap        <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_xfer && in_is_key) begin
            keyin[143 - 9*int'(kcnt) -: 9] <= in_data;
            kcnt <= kcnt + 4'd1;
            if (kcnt == 4'd0)  key_loaded <= 1'b0;
            if (kcnt == 4'd15) key_loaded <= 1'b1;
          end else if (in_xfer) begin
            S_I[35 - 9*int'(bcnt) -: 9] <= in_data;
            bcnt <= bcnt + 2'd1;
          end
        end
        START: begin
          // A done level left over from the previous operation must clear before starting.
          if (!encr_done) begin
            encrypt_en <= 1'b1;
            tcnt       <= '0;
            err        <= 1'b0;
            ocnt       <= '0;
          end
        end
        WAIT: begin
          if (encr_done) begin
            cap        <= S_j;
            encrypt_en <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tmo) begin
              err        <= 1'b1;
              encrypt_en <= 1'b0;
              bcnt       <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            cap  <= {cap[26:0], 9'd0};
            ocnt <= ocnt + 2'd1;
            if (ocnt == 2'd3) bcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_stream_feeder.sv
// Directed bench for enc_stream_feeder with TIMEOUT=8; the core is emulated by hand-driven encr_done/S_j.
module tb_enc_stream_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   in_data;
  logic         in_valid;
  logic         in_is_key;
  logic         in_ready;
  logic [143:0] keyin;
  logic [35:0]  S_I;
  logic         encrypt_en;
  logic         encr_done;
  logic [35:0]  S_j;
  logic [8:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         key_loaded;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  enc_stream_feeder #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_is_key  (in_is_key),
    .in_ready   (in_ready),
    .keyin      (keyin),
    .S_I        (S_I),
    .encrypt_en (encrypt_en),
    .encr_done  (encr_done),
    .S_j        (S_j),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_loaded (key_loaded),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send(input logic [8:0] d, input logic k);
    int n = 0;
    in_data = d; in_is_key = k; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // From #1 inside WAIT: lat idle cycles, then a one-cycle done pulse; returns in M+1.
  task automatic run_core(input int lat, input logic [35:0] sj);
    repeat (lat) begin @(posedge clk); #1; end
    S_j = sj; encr_done = 1'b1;
    @(posedge clk); #1;
    encr_done = 1'b0;
    chk("done_en_low", encrypt_en, 1'b0);
    chk("done_vld", out_valid, 1'b1);
  endtask

  task automatic drain(input logic [7:0] pat, input logic [35:0] sj, output int cyc);
    int cnt = 0;
    logic [35:0] sh;
    sh = sj;
    cyc = 0;
    while (cnt < 4 && cyc < 40) begin
      out_ready = pat[cyc % 8];
      @(negedge clk);
      chk("drain_vld", out_valid, 1'b1);
      chk("drain_dat", out_data, sh[35:27]);
      if (out_ready) begin
        cnt++;
        sh = sh << 9;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_cnt", cnt, 4);
    chk("drain_end_vld", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [143:0] ek;
    int cyc;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_is_key = 1'b0;
    encr_done = 1'b0; S_j = '0; out_ready = 1'b0;
    #3;
    chk("rst_keyin", keyin, 144'd0);
    chk("rst_si", S_I, 36'd0);
    chk("rst_en", encrypt_en, 1'b0);
    chk("rst_odat", out_data, 9'd0);
    chk("rst_ovld", out_valid, 1'b0);
    chk("rst_kl", key_loaded, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Data word refused before any key
    in_data = 9'h1AB; in_is_key = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("nokey_rdy", in_ready, 1'b0);
    @(posedge clk); #1; in_valid = 1'b0;

    ek = '0;
    for (int k = 0; k < 16; k++) ek[143 - 9*k -: 9] = 9'(k + 1);
    for (int k = 0; k < 15; k++) send(9'(k + 1), 1'b1);
    chk("kl_at15", key_loaded, 1'b0);
    send(9'h010, 1'b1);
    chk("kl_at16", key_loaded, 1'b1);
    chk("keyin", keyin, ek);

    // Block 1: full-rate drain, exact timing
    send(9'h1AB, 1'b0); send(9'h0CD, 1'b0); send(9'h1EF, 1'b0); send(9'h012, 1'b0);
    chk("b1_start_en", encrypt_en, 1'b0);
    chk("b1_busy", busy, 1'b1);
    chk("b1_si", S_I, {9'h1AB, 9'h0CD, 9'h1EF, 9'h012});
    @(posedge clk); #1;
    chk("b1_en", encrypt_en, 1'b1);
    run_core(5, 36'h123456789);
    chk("b1_w0", out_data, 9'h024);
    drain(8'hFF, 36'h123456789, cyc);
    chk("b1_cycles", cyc, 4);
    in_is_key = 1'b0;
    #0 chk("b1_rdy_again", in_ready, 1'b1);

    // Block 2: back-pressured drain
    send(9'h001, 1'b0); send(9'h002, 1'b0); send(9'h003, 1'b0); send(9'h004, 1'b0);
    @(posedge clk); #1;
    chk("b2_en", encrypt_en, 1'b1);
    out_ready = 1'b0;
    run_core(5, 36'hFEDCBA987);
    drain(8'b1011_0010, 36'hFEDCBA987, cyc);
    chk("b2_si_hold", S_I, {9'h001, 9'h002, 9'h003, 9'h004});

    // Block 3: core never answers
    send(9'h0AA, 1'b0); send(9'h0BB, 1'b0); send(9'h0CC, 1'b0); send(9'h0DD, 1'b0);
    @(posedge clk); #1;
    chk("b3_en", encrypt_en, 1'b1);
    repeat (7) begin @(posedge clk); #1; end
    chk("b3_busy7", busy, 1'b1);
    chk("b3_err7", err, 1'b0);
    chk("b3_vld7", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("tmo_err", err, 1'b1);
    chk("tmo_en", encrypt_en, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_vld", out_valid, 1'b0);

    send(9'h111, 1'b0); send(9'h122, 1'b0); send(9'h133, 1'b0); send(9'h144, 1'b0);
    chk("b4_err_start", err, 1'b1);
    @(posedge clk); #1;
    chk("b4_err_clr", err, 1'b0);
    chk("b4_en", encrypt_en, 1'b1);
    run_core(3, 36'h0F0F0F0F0);
    drain(8'hFF, 36'h0F0F0F0F0, cyc);

    // Block 5: key word mid-block, stale done at START
    send(9'h0A1, 1'b0); send(9'h0A2, 1'b0);
    in_data = 9'h1FF; in_is_key = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("midblk_key_rdy", in_ready, 1'b0);
    @(posedge clk); #1; in_valid = 1'b0;
    encr_done = 1'b1; S_j = 36'h5A5A5A5A5;
    send(9'h0A3, 1'b0); send(9'h0A4, 1'b0);
    repeat (3) begin
      chk("stale_en", encrypt_en, 1'b0);
      chk("stale_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    chk("stale_en_last", encrypt_en, 1'b0);
    encr_done = 1'b0;
    @(posedge clk); #1;
    chk("stale_en_rise", encrypt_en, 1'b1);
    in_is_key = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("wait_key_rdy", in_ready, 1'b0);
    @(posedge clk); #1; in_valid = 1'b0;
    run_core(1, 36'h13579BDF0);
    drain(8'hFF, 36'h13579BDF0, cyc);

    // Key reload after drain: first word clears key_loaded
    send(9'h1FF, 1'b1);
    chk("rl_kl0", key_loaded, 1'b0);
    chk("rl_w0", keyin[143:135], 9'h1FF);
    for (int k = 1; k < 16; k++) send(9'(k + 1), 1'b1);
    ek[143:135] = 9'h1FF;
    chk("rl_kl1", key_loaded, 1'b1);
    chk("rl_keyin", keyin, ek);

    // Reset in WAIT
    send(9'h0E1, 1'b0); send(9'h0E2, 1'b0); send(9'h0E3, 1'b0); send(9'h0E4, 1'b0);
    @(posedge clk); #1;
    chk("b6_en", encrypt_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_en", encrypt_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_kl", key_loaded, 1'b0);
    chk("arst_keyin", keyin, 144'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_data = 9'h0E1; in_is_key = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
